irq_ack_ctrl: RTL and testbench
===============================

Name: irq_ack_ctrl

Overview:
- Interrupt collection and acknowledge stage. Sits directly upstream of the grant stage on the shared handshake interface.
- Captures rising edges on up to NUM_SRC raw interrupt lines into pending latches, applies a mask, and picks one pending source round-robin.
- Presents the selected source one-hot on irq_out with ack high, holds it until the downstream stage returns gnt, then retires that source.

Parameters:
- NUM_SRC, 8, number of interrupt sources; width of all per-source vectors.
- TIMEOUT_CYC, 16, ACK-state cycle limit before abort; used only with IRQ_TIMEOUT_EN; legal range 2..255.

Ports:
- clk  input  1  single clock; all state on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- irq_in  input  NUM_SRC  raw interrupt request lines, synchronous to clk.
- irq_mask  input  NUM_SRC  1 = source masked.
- gnt  input  1  grant from the downstream stage.
- ack  output  1  service request to the downstream stage.
- irq_out  output  NUM_SRC  one-hot source under service; 0 when not in ACK.
- pending  output  NUM_SRC  current pending latches.
- busy  output  1  high when state is not IDLE.
- timeout  output  1  one-cycle abort pulse.

Behaviour:
- Reset (async assert, sync release): state=IDLE, irq_q=0, pending=0, rr_ptr=0, ack=0, irq_out=0, timeout=0, busy=0. Assertion mid-service drops ack and irq_out immediately.
- Edge capture:
  - irq_q registers irq_in every cycle.
  - For each i, if irq_in[i] & ~irq_q[i] & ~irq_mask[i], pending[i] is set at the next edge.
  - Edges on masked sources are discarded, not deferred.
  - A level held high produces one capture only.
- Eligible vector = pending & ~irq_mask.
  - Masking a pending source makes it ineligible but keeps it latched.
  - Unmasking that source makes it eligible again.
- Round-robin selection: search eligible indices rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_SRC. The first hit wins.
- FSM:
  - IDLE: if eligible != 0, then at the next edge ack=1, irq_out=onehot(winner), latch winner index, go to ACK. Otherwise stay.
  - ACK: ack and irq_out held stable.
    - Mask changes do not affect the source in service.
    - If gnt=1 is sampled, then at the next edge ack=0, irq_out=0, pending[winner] is cleared, rr_ptr=(winner+1) mod NUM_SRC, go to GAP.
    - ACK lasts at least one cycle even if gnt is already high on entry.
  - GAP: exactly one cycle with ack=0, then IDLE. This guarantees a visible ack deassertion between services, because the downstream gnt may remain high.
- Latency: an irq_in rise sampled at edge k sets pending at edge k; ack rises at edge k+1 if the FSM is idle.
- Back-to-back services: minimum 3 cycles ack-to-ack (ACK, GAP, IDLE).
- Simultaneous events:
  - A new rising edge on the winner in its clearing cycle wins: pending stays set, and the source is served again later.
  - Multiple simultaneous edges are all captured in the same cycle.
- busy = (state != IDLE).

Optional Feature:
- Macro: IRQ_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on ACK entry and increments each ACK cycle without gnt.
  - When the count reaches TIMEOUT_CYC-1 with gnt still low, then at the next edge: ack=0, irq_out=0, timeout=1 for one cycle, pending[winner] is kept, rr_ptr=(winner+1) mod NUM_SRC, go to GAP.
  - gnt and timeout reached in the same cycle: gnt wins (normal completion, no pulse).
- Undefined: no counter; ACK waits indefinitely; timeout is tied to 0.

Test Plan:
- Reset then irq_in=8'h04 from cycle 2 -> pending=8'h04 one edge later, ack=1 with irq_out=8'h04 the next edge; gnt=1 -> ack=0, pending=0, busy drops after GAP.
- irq_in=8'h81 together, gnt held high -> serviced in order 8'h01 then 8'h80, each ack separated by a GAP cycle; rr_ptr=0 after the second service.
- irq_mask=8'h02, pulse irq_in[1] -> pending stays 0; pulse irq_in[3] while irq_in[1] is held high -> only 8'h08 is served.
- ack high for 8'h10, irq_in[4] re-rises in the gnt completion cycle -> pending[4] stays 1, and 8'h10 is acknowledged again after GAP.
- rst_n asserted mid-ACK for 8'h20 -> ack, irq_out, and pending are 0 immediately; no ack after release until a new edge.
- With IRQ_TIMEOUT_EN and TIMEOUT_CYC=16, gnt stuck 0 for irq_in=8'h01 -> ack drops after 16 ACK cycles, one-cycle timeout pulse, pending stays 8'h01, and 8'h01 is re-served after GAP (only eligible source).

Source files
------------

// File: rtl/irq_ack_ctrl.sv
// Interrupt edge capture, masking, round-robin pick and ack/gnt handshake toward the grant stage.
// Optional ACK-state abort counter enabled by defining IRQ_TIMEOUT_EN.
module irq_ack_ctrl #(
  parameter int unsigned NUM_SRC     = 8,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic [NUM_SRC-1:0] irq_mask,
  input  logic               gnt,
  output logic               ack,
  output logic [NUM_SRC-1:0] irq_out,
  output logic [NUM_SRC-1:0] pending,
  output logic               busy,
  output logic               timeout
);

  localparam int unsigned IdxW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYC must lie in 2..255");
  end

  typedef enum logic [1:0] {StIdle, StAck, StGap} state_e;

  state_e             state_q;
  logic [NUM_SRC-1:0] irq_q, pending_q, pending_d;
  logic [NUM_SRC-1:0] rise, eligible, clr, sel_onehot, irq_out_q;
  logic [IdxW-1:0]    rr_ptr_q, win_idx_q, sel_idx, next_ptr, cand_idx;
  logic               sel_found, ack_q;
  int unsigned        cand;
`ifdef IRQ_TIMEOUT_EN
  logic [7:0]         cnt_q;
  logic               timeout_q;
`endif

  assign rise     = irq_in & ~irq_q & ~irq_mask;
  assign eligible = pending_q & ~irq_mask;
  // A fresh edge on the retiring source overrides its clear.
  assign clr       = (state_q == StAck && gnt) ? irq_out_q : '0;
  assign pending_d = (pending_q & ~clr) | rise;
  assign next_ptr  = (32'(win_idx_q) == NUM_SRC - 1) ? '0 : win_idx_q + 1'b1;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      cand     = (32'(rr_ptr_q) + k) % NUM_SRC;
      cand_idx = IdxW'(cand);
      if (!sel_found && eligible[cand_idx]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx;
      end
    end
  end

  assign sel_onehot = NUM_SRC'(1) << sel_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      irq_q     <= '0;
      pending_q <= '0;
      rr_ptr_q  <= '0;
      win_idx_q <= '0;
      ack_q     <= 1'b0;
      irq_out_q <= '0;
`ifdef IRQ_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      irq_q     <= irq_in;
      pending_q <= pending_d;
`ifdef IRQ_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        StIdle: begin
          if (sel_found) begin
            state_q   <= StAck;
            ack_q     <= 1'b1;
            irq_out_q <= sel_onehot;
            win_idx_q <= sel_idx;
`ifdef IRQ_TIMEOUT_EN
            cnt_q     <= '0;
`endif
          end
        end
        StAck: begin
          if (gnt) begin
            state_q   <= StGap;
            ack_q     <= 1'b0;
            irq_out_q <= '0;
            rr_ptr_q  <= next_ptr;
          end
`ifdef IRQ_TIMEOUT_EN
          else if (cnt_q == 8'(TIMEOUT_CYC - 1)) begin
            // Abort keeps the source pending but moves the pointer past it.
            state_q   <= StGap;
            ack_q     <= 1'b0;
            irq_out_q <= '0;
            rr_ptr_q  <= next_ptr;
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
`endif
        end
        StGap:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ack     = ack_q;
  assign irq_out = irq_out_q;
  assign pending = pending_q;
  assign busy    = (state_q != StIdle);
`ifdef IRQ_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_irq_ack_ctrl.sv
// Self-checking bench for irq_ack_ctrl: directed scenarios plus randomized traffic against a
// behavioural service model (source in service, gap flag, pending set, round-robin pointer).
module tb_irq_ack_ctrl;

  localparam int N  = 8;
  localparam int TO = 16;
`ifdef IRQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] irq_in = '0;
  logic [N-1:0] irq_mask = '0;
  logic         gnt = 1'b0;
  logic         ack, busy, timeout;
  logic [N-1:0] irq_out, pending;

  int vectors = 0;
  int miscompares = 0;

  irq_ack_ctrl #(.NUM_SRC(N), .TIMEOUT_CYC(TO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .irq_in   (irq_in),
    .irq_mask (irq_mask),
    .gnt      (gnt),
    .ack      (ack),
    .irq_out  (irq_out),
    .pending  (pending),
    .busy     (busy),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  // Model: m_srv is the index under service (-1 when none), m_gap marks the spacer cycle.
  logic [N-1:0] m_prev, m_pend;
  int           m_rr, m_srv, m_cnt;
  bit           m_gap, m_to;

  task automatic model_reset();
    m_prev = '0; m_pend = '0; m_rr = 0; m_srv = -1; m_cnt = 0; m_gap = 0; m_to = 0;
  endtask

  task automatic model_update();
    logic [N-1:0] rise, elig;
    int win;
    if (!rst_n) begin
      model_reset();
      return;
    end
    rise = irq_in & ~m_prev & ~irq_mask;
    elig = m_pend & ~irq_mask;
    m_to = 0;
    if (m_srv >= 0) begin
      if (gnt) begin
        m_pend[m_srv] = 1'b0;
        m_rr = (m_srv + 1) % N;
        m_srv = -1;
        m_gap = 1;
      end else if (TO_EN && m_cnt == TO - 1) begin
        m_to = 1;
        m_rr = (m_srv + 1) % N;
        m_srv = -1;
        m_gap = 1;
      end else begin
        m_cnt++;
      end
    end else if (m_gap) begin
      m_gap = 0;
    end else begin
      win = -1;
      for (int k = 0; k < N; k++)
        if (win < 0 && elig[(m_rr + k) % N]) win = (m_rr + k) % N;
      if (win >= 0) begin
        m_srv = win;
        m_cnt = 0;
      end
    end
    m_pend = m_pend | rise;
    m_prev = irq_in;
  endtask

  function automatic logic [2*N+2:0] mdl_vec();
    logic         a;
    logic [N-1:0] o;
    a = (m_srv >= 0);
    o = a ? (N'(1) << m_srv) : '0;
    return {a, o, m_pend, a | m_gap, m_to};
  endfunction

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; irq_in = '0; irq_mask = '0; gnt = 1'b0;
    #1;
    model_reset();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      step();
      vectors++;
      if ({ack, irq_out, pending, busy, timeout} !== '0) begin
        miscompares++;
        $display("FAIL reset_state cyc=%0d got=%h exp=0", c,
                 {ack, irq_out, pending, busy, timeout});
      end
    end
  endtask

  task automatic test_single();
    logic [N-1:0] seq_in[10]  = '{8'h00, 8'h04, 8'h04, 8'h04, 8'h04, 8'h04, 8'h00, 8'h00,
                                  8'h00, 8'h00};
    logic         seq_gnt[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    do_reset();
    for (int c = 0; c < 10; c++) begin
      irq_in = seq_in[c]; gnt = seq_gnt[c];
      step();
      vectors++;
      if ({ack, irq_out, pending, busy, timeout} !== mdl_vec()) begin
        miscompares++;
        $display("FAIL single cyc=%0d got=%h exp=%h", c,
                 {ack, irq_out, pending, busy, timeout}, mdl_vec());
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    gnt = 1'b1;
    for (int c = 0; c < 18; c++) begin
      irq_in = (c == 0 || c == 10) ? 8'h81 : 8'h00;
      step();
      vectors++;
      if ({ack, irq_out, pending, busy, timeout} !== mdl_vec()) begin
        miscompares++;
        $display("FAIL back_to_back cyc=%0d got=%h exp=%h", c,
                 {ack, irq_out, pending, busy, timeout}, mdl_vec());
      end
    end
    gnt = 1'b0;
  endtask

  task automatic test_mask();
    logic [N-1:0] seq_in[12] = '{8'h02, 8'h00, 8'h02, 8'h02, 8'h0a, 8'h02, 8'h02, 8'h02,
                                 8'h02, 8'h02, 8'h02, 8'h00};
    do_reset();
    irq_mask = 8'h02;
    for (int c = 0; c < 12; c++) begin
      irq_in = seq_in[c];
      gnt = (c >= 7);
      step();
      vectors++;
      if ({ack, irq_out, pending, busy, timeout} !== mdl_vec()) begin
        miscompares++;
        $display("FAIL mask cyc=%0d got=%h exp=%h", c,
                 {ack, irq_out, pending, busy, timeout}, mdl_vec());
      end
    end
    irq_mask = '0;
  endtask

  task automatic test_rerise();
    logic [N-1:0] seq_in[12]  = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h10, 8'h10, 8'h10, 8'h10,
                                  8'h10, 8'h10, 8'h00, 8'h00};
    logic         seq_gnt[12] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0};
    do_reset();
    for (int c = 0; c < 12; c++) begin
      irq_in = seq_in[c]; gnt = seq_gnt[c];
      step();
      vectors++;
      if ({ack, irq_out, pending, busy, timeout} !== mdl_vec()) begin
        miscompares++;
        $display("FAIL rerise cyc=%0d got=%h exp=%h", c,
                 {ack, irq_out, pending, busy, timeout}, mdl_vec());
      end
      if (c == 4) begin
        vectors++;
        if (pending !== 8'h10 || ack !== 1'b0) begin
          miscompares++;
          $display("FAIL rerise_kept got pending=%h ack=%b exp pending=10 ack=0", pending, ack);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      irq_in = (c == 0) ? 8'h20 : 8'h00;
      step();
      vectors++;
      if ({ack, irq_out, pending, busy, timeout} !== mdl_vec()) begin
        miscompares++;
        $display("FAIL pre_reset cyc=%0d got=%h exp=%h", c,
                 {ack, irq_out, pending, busy, timeout}, mdl_vec());
      end
    end
    #3 rst_n = 1'b0;
    #1;
    vectors++;
    if ({ack, irq_out, pending} !== '0) begin
      miscompares++;
      $display("FAIL async_reset got ack=%b irq_out=%h pending=%h exp all 0", ack, irq_out, pending);
    end
    model_reset();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      vectors++;
      if ({ack, irq_out, pending, busy, timeout} !== mdl_vec()) begin
        miscompares++;
        $display("FAIL post_reset cyc=%0d got=%h exp=%h", c,
                 {ack, irq_out, pending, busy, timeout}, mdl_vec());
      end
    end
  endtask

  // Without the timeout feature this checks ack is held indefinitely; with it, the abort.
  task automatic test_timeout();
    do_reset();
    for (int c = 0; c < 45; c++) begin
      irq_in = (c == 0) ? 8'h01 : 8'h00;
      gnt = (c >= 40);
      step();
      vectors++;
      if ({ack, irq_out, pending, busy, timeout} !== mdl_vec()) begin
        miscompares++;
        $display("FAIL timeout cyc=%0d got=%h exp=%h", c,
                 {ack, irq_out, pending, busy, timeout}, mdl_vec());
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 2) == 0) irq_in = irq_in ^ N'($urandom);
      if ($urandom_range(0, 15) == 0) irq_mask = N'($urandom) & N'($urandom);
      gnt = ($urandom_range(0, 2) == 0);
      step();
      vectors++;
      if ({ack, irq_out, pending, busy, timeout} !== mdl_vec()) begin
        miscompares++;
        $display("FAIL random cyc=%0d got=%h exp=%h", c,
                 {ack, irq_out, pending, busy, timeout}, mdl_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_mask();
    test_rerise();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
